// File: rtl/img_pkg.sv
// Shared types and default frame geometry for the image filter / serializer path.
package img_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam int unsigned W_PIX     = 8;
  localparam int unsigned FRAME_R   = 16;
  localparam int unsigned FRAME_C   = 16;
  localparam int unsigned FRAME_PAD = 1;

endpackage

// File: rtl/frame_scan_counter.sv
// Row/column scan over the unpadded interior of a frame, row-major, with wrap flags.
module frame_scan_counter
  import img_pkg::*;
#(
  parameter int unsigned R_I = FRAME_R,
  parameter int unsigned C_I = FRAME_C,
  parameter int unsigned PAD = FRAME_PAD,
  localparam int unsigned RW = $clog2(R_I),
  localparam int unsigned CW = $clog2(C_I)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          clear,
  input  logic          step,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last_col,
  output logic          last_pix
);

  localparam logic [RW-1:0] ROW_FIRST = RW'(PAD);
  localparam logic [RW-1:0] ROW_LAST  = RW'(R_I - 1 - PAD);
  localparam logic [CW-1:0] COL_FIRST = CW'(PAD);
  localparam logic [CW-1:0] COL_LAST  = CW'(C_I - 1 - PAD);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_last_col;
  logic          r_last_pix;
  logic [RW-1:0] w_nxt_row;
  logic [CW-1:0] w_nxt_col;

  assign w_nxt_col = r_last_col ? COL_FIRST : r_col + CW'(1);
  assign w_nxt_row = r_last_col ? r_row + RW'(1) : r_row;

  // Last-column / last-pixel flags are registered alongside the position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row      <= ROW_FIRST;
      r_col      <= COL_FIRST;
      r_last_col <= (COL_FIRST == COL_LAST);
      r_last_pix <= (COL_FIRST == COL_LAST) && (ROW_FIRST == ROW_LAST);
    end else if (cen) begin
      if (clear) begin
        r_row      <= ROW_FIRST;
        r_col      <= COL_FIRST;
        r_last_col <= (COL_FIRST == COL_LAST);
        r_last_pix <= (COL_FIRST == COL_LAST) && (ROW_FIRST == ROW_LAST);
      end else if (step) begin
        r_row      <= w_nxt_row;
        r_col      <= w_nxt_col;
        r_last_col <= (w_nxt_col == COL_LAST);
        r_last_pix <= (w_nxt_col == COL_LAST) && (w_nxt_row == ROW_LAST);
      end
    end
  end

  assign row      = r_row;
  assign col      = r_col;
  assign last_col = r_last_col;
  assign last_pix = r_last_pix;

endmodule

// File: rtl/image_serializer.sv
// Captures a padded frame in one cycle and streams its interior pixels row-major
// over a valid/ready interface with sof/eol/eof framing.
module image_serializer
  import img_pkg::*;
#(
  parameter int unsigned R_I = FRAME_R,
  parameter int unsigned C_I = FRAME_C,
  parameter int unsigned W_I = W_PIX,
  parameter int unsigned PAD = FRAME_PAD
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cen,
  input  logic                             load,
  input  logic [R_I-1:0][C_I-1:0][W_I-1:0] img,
  output logic                             busy,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [W_I-1:0]                   m_data,
  output logic                             m_sof,
  output logic                             m_eol,
  output logic                             m_eof,
  output logic                             frame_done
);

  localparam int unsigned RW = $clog2(R_I);
  localparam int unsigned CW = $clog2(C_I);
  localparam logic [RW-1:0] ROW_LAST = RW'(R_I - 1 - PAD);
  localparam logic [CW-1:0] COL_LAST = CW'(C_I - 1 - PAD);
  localparam logic          ONE_COL  = (PAD == C_I - 1 - PAD);
  localparam logic          ONE_ROW  = (PAD == R_I - 1 - PAD);

  state_t                             r_state;
  logic [R_I-1:0][C_I-1:0][W_I-1:0]   r_buf;
  logic                               r_busy;
  logic                               r_m_valid;
  logic [W_I-1:0]                     r_m_data;
  logic                               r_m_sof;
  logic                               r_m_eol;
  logic                               r_m_eof;
  logic                               r_frame_done;

  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic          w_last_col;
  logic          w_last_pix;
  logic [RW-1:0] w_nxt_row;
  logic [CW-1:0] w_nxt_col;
  logic          w_accept;
  logic          w_xfer;
  logic          w_clear;
  logic          w_step;

  assign w_accept = load & (r_state == IDLE);
  assign w_xfer   = m_ready & (r_state == STREAM);
  assign w_clear  = w_accept | (w_xfer & w_last_pix);
  assign w_step   = w_xfer & ~w_last_pix;

  // Lookahead position so the output registers already hold the next pixel.
  assign w_nxt_col = w_last_col ? CW'(PAD) : w_col + CW'(1);
  assign w_nxt_row = w_last_col ? w_row + RW'(1) : w_row;

  frame_scan_counter #(
    .R_I (R_I),
    .C_I (C_I),
    .PAD (PAD)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .clear    (w_clear),
    .step     (w_step),
    .row      (w_row),
    .col      (w_col),
    .last_col (w_last_col),
    .last_pix (w_last_pix)
  );

  always_ff @(posedge clk) begin
    if (cen && w_accept) begin
      r_buf <= img;
    end
  end

  // First pixel comes straight from img since the buffer is written on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_sof      <= 1'b0;
      r_m_eol      <= 1'b0;
      r_m_eof      <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (cen) begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load) begin
            r_state   <= STREAM;
            r_busy    <= 1'b1;
            r_m_valid <= 1'b1;
            r_m_data  <= img[PAD][PAD];
            r_m_sof   <= 1'b1;
            r_m_eol   <= ONE_COL;
            r_m_eof   <= ONE_COL && ONE_ROW;
          end
        end
        STREAM: begin
          if (m_ready) begin
            if (w_last_pix) begin
              r_state      <= IDLE;
              r_busy       <= 1'b0;
              r_m_valid    <= 1'b0;
              r_m_sof      <= 1'b0;
              r_m_eol      <= 1'b0;
              r_m_eof      <= 1'b0;
              r_frame_done <= 1'b1;
            end else begin
              r_m_data <= r_buf[w_nxt_row][w_nxt_col];
              r_m_sof  <= 1'b0;
              r_m_eol  <= (w_nxt_col == COL_LAST);
              r_m_eof  <= (w_nxt_col == COL_LAST) && (w_nxt_row == ROW_LAST);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_sof      = r_m_sof;
  assign m_eol      = r_m_eol;
  assign m_eof      = r_m_eof;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_image_serializer.sv
// Bench for image_serializer: directed scenarios plus random traffic against a
// queue-based transaction model of the expected pixel stream.
module tb_image_serializer;

  localparam int unsigned R  = 4;
  localparam int unsigned C  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned P  = 1;

  typedef struct {
    logic [W-1:0] data;
    logic         sof;
    logic         eol;
    logic         eof;
  } pix_t;

  logic                     clk;
  logic                     rst;
  logic                     cen;
  logic                     load;
  logic [R-1:0][C-1:0][W-1:0] img;
  logic                     busy;
  logic                     m_valid;
  logic                     m_ready;
  logic [W-1:0]             m_data;
  logic                     m_sof;
  logic                     m_eol;
  logic                     m_eof;
  logic                     frame_done;

  logic                     load2;
  logic [2:0][2:0][W-1:0]   img2;
  logic                     busy2;
  logic                     m_valid2;
  logic                     m_ready2;
  logic [W-1:0]             m_data2;
  logic                     m_sof2;
  logic                     m_eol2;
  logic                     m_eof2;
  logic                     frame_done2;

  int n_checks = 0;
  int n_err    = 0;
  int n_hs     = 0;

  pix_t         q[$];
  logic         mb   = 1'b0;
  logic         mfd  = 1'b0;
  logic [W-1:0] mlast = '0;

  image_serializer #(.R_I(R), .C_I(C), .W_I(W), .PAD(P)) dut (
    .clk(clk), .rst(rst), .cen(cen), .load(load), .img(img),
    .busy(busy), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof), .frame_done(frame_done)
  );

  image_serializer #(.R_I(3), .C_I(3), .W_I(W), .PAD(1)) dut1x1 (
    .clk(clk), .rst(rst), .cen(cen), .load(load2), .img(img2),
    .busy(busy2), .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2),
    .m_sof(m_sof2), .m_eol(m_eol2), .m_eof(m_eof2), .frame_done(frame_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream for the frame currently on img: interior pixels, row-major.
  task automatic push_frame();
    pix_t p;
    for (int r = P; r <= R - 1 - P; r++) begin
      for (int c = P; c <= C - 1 - P; c++) begin
        p.data = img[r][c];
        p.sof  = (r == P) && (c == P);
        p.eol  = (c == C - 1 - P);
        p.eof  = p.eol && (r == R - 1 - P);
        q.push_back(p);
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && busy; i++) tick();
    check(tag, 64'(busy), 64'(0));
  endtask

  // Per-cycle comparison against the model, then advance the model for the next edge.
  always @(negedge clk) begin : mon
    pix_t e;
    logic fin;
    if (rst) begin
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_valid", 64'(m_valid), 64'(0));
      check("rst_data", 64'(m_data), 64'(0));
      check("rst_flags", 64'({m_sof, m_eol, m_eof}), 64'(0));
      check("rst_done", 64'(frame_done), 64'(0));
      q.delete();
      mb    = 1'b0;
      mfd   = 1'b0;
      mlast = '0;
    end else begin
      check("busy", 64'(busy), 64'(mb));
      check("valid", 64'(m_valid), 64'(mb));
      check("frame_done", 64'(frame_done), 64'(mfd));
      if (mb && q.size() > 0) begin
        e = q[0];
        check("data", 64'(m_data), 64'(e.data));
        check("flags", 64'({m_sof, m_eol, m_eof}), 64'({e.sof, e.eol, e.eof}));
      end else begin
        check("idle_data", 64'(m_data), 64'(mlast));
        check("idle_flags", 64'({m_sof, m_eol, m_eof}), 64'(0));
      end
      if (m_valid && m_ready && cen) n_hs++;
      fin = 1'b0;
      if (cen) begin
        if (!mb) begin
          if (load) begin
            push_frame();
            mb = 1'b1;
          end
        end else if (m_ready && q.size() > 0) begin
          mlast = q[0].data;
          void'(q.pop_front());
          if (q.size() == 0) begin
            mb  = 1'b0;
            fin = 1'b1;
          end
        end
        mfd = fin;
      end
    end
  end

  initial begin
    int h0;
    logic [W-1:0] d0;
    logic [2:0]   s0;
    logic [W-1:0] e2;

    rst = 1'b1; cen = 1'b1; load = 1'b0; m_ready = 1'b1;
    load2 = 1'b0; m_ready2 = 1'b0; img2 = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        img[r][c] = W'(16 * r + c);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single frame, ready held high
    h0 = n_hs;
    load = 1'b1; tick(); load = 1'b0;
    repeat (6) tick();
    check("t1_xfers", 64'(n_hs - h0), 64'(4));

    // Backpressure pattern 1,0,0,1,...
    h0 = n_hs;
    load = 1'b1; tick(); load = 1'b0;
    for (int i = 0; i < 15; i++) begin
      m_ready = (i % 3 == 0);
      tick();
    end
    m_ready = 1'b1;
    wait_idle("t2_drain");
    check("t2_xfers", 64'(n_hs - h0), 64'(4));

    // img changes and load re-pulsed while streaming
    h0 = n_hs;
    load = 1'b1; tick(); load = 1'b0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        img[r][c] = W'($urandom);
    load = 1'b1; tick(); tick(); load = 1'b0;
    repeat (4) tick();
    check("t3_idle", 64'(busy), 64'(0));
    check("t3_xfers", 64'(n_hs - h0), 64'(4));

    // load held through the frame_done cycle: back-to-back frames
    h0 = n_hs;
    load = 1'b1; repeat (6) tick(); load = 1'b0;
    wait_idle("t4_drain");
    check("t4_xfers", 64'(n_hs - h0), 64'(8));

    // cen low for three cycles mid-frame
    load = 1'b1; tick(); load = 1'b0; tick();
    @(negedge clk);
    d0 = m_data; s0 = {m_sof, m_eol, m_eof};
    cen = 1'b0;
    repeat (3) tick();
    check("t5_hold_data", 64'(m_data), 64'(d0));
    check("t5_hold_flags", 64'({m_sof, m_eol, m_eof}), 64'(s0));
    check("t5_hold_busy", 64'(busy), 64'(1));
    cen = 1'b1;
    wait_idle("t5_drain");

    // Reset after the second transfer, then restart
    load = 1'b1; tick(); load = 1'b0; tick(); tick();
    rst = 1'b1;
    #1;
    check("t6_async_valid", 64'(m_valid), 64'(0));
    check("t6_async_busy", 64'(busy), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    check("t6_no_done", 64'(frame_done), 64'(0));
    load = 1'b1; tick(); load = 1'b0;
    wait_idle("t6_drain");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cen     = ($urandom % 5) != 0;
      m_ready = ($urandom % 2) != 0;
      load    = ($urandom % 4) == 0;
      if ($urandom % 8 == 0)
        for (int r = 0; r < R; r++)
          for (int c = 0; c < C; c++)
            img[r][c] = W'($urandom);
      tick();
    end
    cen = 1'b1; m_ready = 1'b1; load = 1'b0;
    wait_idle("t7_drain");

    // Degenerate 1x1 interior
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        img2[r][c] = W'($urandom);
    e2 = img2[1][1];
    load2 = 1'b1; tick(); load2 = 1'b0;
    @(negedge clk);
    check("t8_valid", 64'(m_valid2), 64'(1));
    check("t8_busy", 64'(busy2), 64'(1));
    check("t8_data", 64'(m_data2), 64'(e2));
    check("t8_flags", 64'({m_sof2, m_eol2, m_eof2}), 64'(3'b111));
    m_ready2 = 1'b1; tick(); m_ready2 = 1'b0;
    @(negedge clk);
    check("t8_done", 64'(frame_done2), 64'(1));
    check("t8_end_valid", 64'(m_valid2), 64'(0));
    check("t8_end_busy", 64'(busy2), 64'(0));
    check("t8_end_data", 64'(m_data2), 64'(e2));
    tick();
    @(negedge clk);
    check("t8_done_clear", 64'(frame_done2), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/image_serializer.md
# image_serializer

Frame-to-stream converter on the output side of the image filters. It captures one parallel padded frame produced by the averaging/noise filters in a single cycle, strips the padding border, and emits the remaining pixels in row-major order over a valid/ready stream. The stream feeds the display/UART path.

## Interface
Parameters:
- R_I, 16, rows of the padded input frame
- C_I, 16, columns of the padded input frame
- W_I, 8, bits per pixel
- PAD, 1, border width stripped on every side; requires 2*PAD < R_I and 2*PAD < C_I

Ports:
- clk  in  1  clock; the only clock
- rst  in  1  asynchronous, active-high reset
- cen  in  1  clock enable; when low, all state and outputs hold
- load  in  1  request to capture `img`; sampled only in IDLE
- img  in  [R_I-1:0][C_I-1:0][W_I-1:0]  padded frame, unsigned
- busy  out  1  high in STREAM
- m_valid  out  1  stream pixel valid
- m_ready  in  1  downstream accept
- m_data  out  W_I  pixel value
- m_sof  out  1  first pixel of frame
- m_eol  out  1  last pixel of a row
- m_eof  out  1  last pixel of frame
- frame_done  out  1  one-cycle pulse after the last transfer

## Operation
- Frame buffer: internal copy of `img`, written only on an accepted load. The filters may change `img` freely while streaming.
- State machine, two states:
  - IDLE: `load & cen` captures the frame, sets row=PAD and col=PAD, and moves to STREAM.
  - STREAM: a transfer occurs on `m_valid & m_ready & cen`. Each transfer advances col. At col=C_I-1-PAD, col wraps to PAD and row increments. A transfer at row=R_I-1-PAD, col=C_I-1-PAD returns to IDLE.
- Outputs in STREAM:
  - m_valid=1
  - m_data = buffer[row][col]
  - m_sof = (row==PAD && col==PAD)
  - m_eol = (col==C_I-1-PAD)
  - m_eof = m_eol && (row==R_I-1-PAD)
- Outputs in IDLE: m_valid, m_sof, m_eol, m_eof and busy are all 0. m_data holds its last value.
- Pixel count per frame: (R_I-2*PAD)*(C_I-2*PAD).
- `load` in STREAM is ignored. It is not queued.
- No arithmetic on pixel values; data passes through bit-exact.
- Degenerate 1x1 output (R_I=C_I=2*PAD+1): a single pixel with m_sof, m_eol and m_eof all high.

## Timing
- Reset values: state IDLE; busy, m_valid, m_sof, m_eol, m_eof, frame_done = 0; m_data = 0; row = col = PAD; buffer not reset.
- Load latency: load accepted at edge N means m_valid=1 with the first pixel from edge N onward, i.e. visible in the cycle after load was sampled.
- Throughput: one pixel per cycle while m_ready=1 and cen=1. A frame of P pixels with m_ready held high occupies P cycles of STREAM.
- Backpressure: while m_valid & !m_ready, m_data and all flags stay stable.
- m_valid never drops without a transfer, except on rst.
- frame_done is registered and high for exactly one cycle, starting at the edge that performs the final transfer, coincident with the return to IDLE.
- A load in that same IDLE cycle is accepted, giving back-to-back frames with a one-cycle valid gap.
- cen low:
  - no transfer, no state change;
  - frame_done, if high, stays high until the next cen-high edge clears it;
  - downstream must treat handshakes as qualified by cen.
- rst mid-frame aborts immediately to IDLE with reset values. No frame_done pulse, no partial eof.

## Structure
- Shared package img_pkg:
  - `state_t` enum {IDLE, STREAM};
  - pixel width default constant W_PIX=8;
  - default frame dimension constants shared with averaging and salt-and-pepper filters.
- Sub-module `frame_scan_counter`:
  - parameters R_I, C_I, PAD;
  - ports clk, rst, cen, clear, step;
  - outputs row, col, last_col, last_pix;
  - handles the wrap logic.
- The top level holds the buffer, FSM and output registers.

## Test plan
- R_I=C_I=4, PAD=1, pixel[r][c]=16r+c, m_ready=1, single load → exactly 4 transfers of 0x11, 0x12, 0x21, 0x22:
  - m_sof on 0x11;
  - m_eol on 0x12 and 0x22;
  - m_eof on 0x22;
  - frame_done one cycle at the final transfer edge.
- Same frame, m_ready toggling 1,0,0,1,… → data and flags held stable across stalls, same 4-pixel sequence, no duplicates or drops.
- Change img and pulse load during STREAM → output still from the captured frame; second load ignored, so busy returns low after 4 transfers.
- Load asserted in the frame_done cycle → second frame starts next cycle, with exactly one cycle of m_valid=0 between frames.
- cen=0 for 3 cycles mid-frame with m_ready=1 → no transfers and no state or output change; streaming resumes at the same pixel.
- Assert rst after the 2nd transfer → all outputs 0 asynchronously, busy=0, no frame_done. A subsequent load restarts at pixel 0x11 with m_sof.
